// File: rtl/mips32_run_ctrl.sv
// Run controller for the Mips32 core: load the program image, hold the core in reset, run, supervise.
// Optional MIPS32_RUN_CTRL_RERUN_EN adds a `rerun` input that restarts from a terminal state without reloading.
module mips32_run_ctrl #(
  parameter int unsigned IMEM_ADDR_BITS = 6,
  parameter int unsigned RESET_CYCLES   = 7,
  parameter int unsigned MAX_CYCLES     = 50000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
`ifdef MIPS32_RUN_CTRL_RERUN_EN
  input  logic                      rerun,
`endif
  input  logic                      load_valid,
  input  logic [31:0]               load_data,
  input  logic                      load_last,
  output logic                      load_ready,
  output logic                      imem_wen,
  output logic [IMEM_ADDR_BITS-1:0] imem_waddr,
  output logic [31:0]               imem_wdata,
  output logic                      core_reset,
  input  logic                      core_halted,
  input  logic [31:0]               core_raddr,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic                      fault,
  output logic [IMEM_ADDR_BITS:0]   words_loaded,
  output logic [31:0]               cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE, S_TIMEOUT, S_FAULT
  } state_e;

  state_e                    state_q, state_d;
  logic [IMEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [IMEM_ADDR_BITS:0]   words_q, words_d;
  logic [31:0]               cycle_q, cycle_d;
  logic [7:0]                hold_q, hold_d;
  logic                      halted_q, oob_q;
  logic                      core_reset_q, busy_q, done_q, timeout_q, fault_q;
  logic                      accept;
  logic                      terminal;

  assign load_ready = (state_q == S_LOAD);
  assign accept     = load_valid & load_ready;
  assign imem_wen   = accept;
  assign imem_waddr = addr_q;
  assign imem_wdata = load_ready ? load_data : 32'd0;
  assign terminal   = (state_q == S_DONE) || (state_q == S_TIMEOUT) || (state_q == S_FAULT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    cycle_d = cycle_q;
    hold_d  = hold_q;
    if ((state_q == S_IDLE || terminal) && start) begin
      state_d = S_LOAD;
      addr_d  = '0;
      words_d = '0;
      cycle_d = '0;
`ifdef MIPS32_RUN_CTRL_RERUN_EN
    end else if (terminal && rerun) begin
      state_d = S_HOLD;
      hold_d  = 8'(RESET_CYCLES);
      cycle_d = '0;
`endif
    end else begin
      case (state_q)
        S_LOAD: if (accept) begin
          addr_d  = addr_q + 1'b1;
          words_d = words_q + 1'b1;
          // A full memory ends the load even without load_last.
          if (load_last || (&addr_q)) begin
            state_d = S_HOLD;
            hold_d  = 8'(RESET_CYCLES);
          end
        end
        S_HOLD: begin
          if (hold_q <= 8'd1) state_d = S_RUN;
          else                hold_d  = hold_q - 8'd1;
        end
        S_RUN: begin
          if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
          if (halted_q)                              state_d = S_DONE;
          else if (oob_q)                            state_d = S_FAULT;
          else if ((cycle_q + 32'd1) == MAX_CYCLES)  state_d = S_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      words_q      <= '0;
      cycle_q      <= '0;
      hold_q       <= '0;
      halted_q     <= 1'b0;
      oob_q        <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      cycle_q      <= cycle_d;
      hold_q       <= hold_d;
      halted_q     <= core_halted;
      oob_q        <= |(core_raddr >> IMEM_ADDR_BITS);
      core_reset_q <= (state_d != S_RUN);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_HOLD) || (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
      timeout_q    <= (state_d == S_TIMEOUT);
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign fault        = fault_q;
  assign words_loaded = words_q;
  assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Directed bench for mips32_run_ctrl (built with MAX_CYCLES=20 so the timeout path is reachable).
module tb_mips32_run_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        rerun = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        imem_wen;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        core_halted = 1'b0;
  logic [31:0] core_raddr = 32'd0;
  logic        busy, done, timeout, fault;
  logic [6:0]  words_loaded;
  logic [31:0] cycle_count;

  int ncmp = 0;
  int nerr = 0;
  int nw = 0;
  logic [5:0]  log_addr [0:255];
  logic [31:0] log_data [0:255];

  always #5 clock = ~clock;

  mips32_run_ctrl #(.IMEM_ADDR_BITS(6), .RESET_CYCLES(7), .MAX_CYCLES(20)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
`ifdef MIPS32_RUN_CTRL_RERUN_EN
    .rerun(rerun),
`endif
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .imem_wen(imem_wen), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .core_halted(core_halted),
    .core_raddr(core_raddr), .busy(busy), .done(done), .timeout(timeout),
    .fault(fault), .words_loaded(words_loaded), .cycle_count(cycle_count)
  );

  // Log every instruction-memory write in order.
  always @(posedge clock) begin
    if (imem_wen && nw < 256) begin
      log_addr[nw] <= imem_waddr;
      log_data[nw] <= imem_wdata;
      nw <= nw + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Counts cycles with core_reset high until RUN is reached (bounded).
  task automatic wait_run(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 50) begin n++; tick(); end
  endtask

  task automatic wait_term(output int n);
    n = 0;
    while (!(done || timeout || fault) && n < 50) begin n++; tick(); end
  endtask

  task automatic load_one(input logic [31:0] d);
    load_valid = 1'b1; load_data = d; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    ncmp++; if ({core_reset, busy, done, timeout, fault, load_ready, imem_wen} !== 7'b1000000) begin
      nerr++; $display("FAIL reset_flags got=%b exp=1000000", {core_reset, busy, done, timeout, fault, load_ready, imem_wen}); end
    ncmp++; if ({imem_waddr, imem_wdata, words_loaded, cycle_count} !== '0) begin
      nerr++; $display("FAIL reset_values addr=%0h data=%0h words=%0d cyc=%0d", imem_waddr, imem_wdata, words_loaded, cycle_count); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load_run();
    logic [31:0] prog [4];
    int base, n;
    prog[0] = 32'h20010005; prog[1] = 32'h20020007; prog[2] = 32'h00221820; prog[3] = 32'h0000000D;
    base = nw;
    pulse_start();
    ncmp++; if ({load_ready, busy, core_reset} !== 3'b111) begin
      nerr++; $display("FAIL load_entry got=%b exp=111", {load_ready, busy, core_reset}); end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3); tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    ncmp++; if (nw - base !== 4) begin nerr++; $display("FAIL basic_write_count got=%0d exp=4", nw - base); end
    for (int i = 0; i < 4; i++) begin
      ncmp++; if (log_addr[base+i] !== 6'(i) || log_data[base+i] !== prog[i]) begin
        nerr++; $display("FAIL basic_write%0d got=%0h:%0h exp=%0h:%0h", i, log_addr[base+i], log_data[base+i], i, prog[i]); end
    end
    ncmp++; if (words_loaded !== 7'd4) begin nerr++; $display("FAIL basic_words got=%0d exp=4", words_loaded); end
    wait_run(n);
    ncmp++; if (n !== 7) begin nerr++; $display("FAIL basic_hold_cycles got=%0d exp=7", n); end
    repeat (4) tick();
    core_halted = 1'b1;
    wait_term(n);
    core_halted = 1'b0;
    ncmp++; if ({done, timeout, fault, core_reset, busy} !== 5'b10010) begin
      nerr++; $display("FAIL basic_done_flags got=%b exp=10010", {done, timeout, fault, core_reset, busy}); end
    ncmp++; if (cycle_count !== 32'd6) begin nerr++; $display("FAIL basic_cycle_count got=%0d exp=6", cycle_count); end
    tick();
    ncmp++; if ({cycle_count, words_loaded} !== {32'd6, 7'd4}) begin
      nerr++; $display("FAIL basic_hold_values got=%0d/%0d exp=6/4", cycle_count, words_loaded); end
  endtask

  task automatic test_toggle_valid();
    int base, n, k;
    logic v;
    base = nw;
    pulse_start();
    ncmp++; if ({words_loaded, cycle_count} !== '0) begin
      nerr++; $display("FAIL toggle_clear got=%0d/%0d exp=0/0", words_loaded, cycle_count); end
    k = 0;
    for (int s = 0; s < 7; s++) begin
      v = (s % 2 == 0);
      load_valid = v; load_data = 32'hA0 + k; load_last = (s == 6);
      start = (s == 3);  // ignored in LOAD
      #1;
      ncmp++; if (imem_wen !== v) begin nerr++; $display("FAIL toggle_wen%0d got=%b exp=%b", s, imem_wen, v); end
      tick();
      if (v) k++;
    end
    load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
    ncmp++; if (nw - base !== 4) begin nerr++; $display("FAIL toggle_write_count got=%0d exp=4", nw - base); end
    for (int i = 0; i < 4; i++) begin
      ncmp++; if (log_addr[base+i] !== 6'(i) || log_data[base+i] !== 32'hA0 + i) begin
        nerr++; $display("FAIL toggle_write%0d got=%0h:%0h exp=%0h:%0h", i, log_addr[base+i], log_data[base+i], i, 32'hA0 + i); end
    end
    wait_run(n);
    ncmp++; if (n !== 7) begin nerr++; $display("FAIL toggle_hold_cycles got=%0d exp=7", n); end
    core_raddr = 32'd64;
    wait_term(n);
    core_raddr = 32'd0;
    ncmp++; if ({fault, done, timeout, core_reset} !== 4'b1001) begin
      nerr++; $display("FAIL oob_fault got=%b exp=1001", {fault, done, timeout, core_reset}); end
    ncmp++; if (cycle_count !== 32'd2) begin nerr++; $display("FAIL oob_cycle_count got=%0d exp=2", cycle_count); end
  endtask

  task automatic test_full_load();
    int base, n;
    base = nw;
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1; load_data = 32'h1000 + i; load_last = 1'b0; tick();
    end
    ncmp++; if ({load_ready, busy, core_reset} !== 3'b011) begin
      nerr++; $display("FAIL full_hold_entry got=%b exp=011", {load_ready, busy, core_reset}); end
    ncmp++; if (words_loaded !== 7'd64) begin nerr++; $display("FAIL full_words got=%0d exp=64", words_loaded); end
    tick();
    load_valid = 1'b0;
    ncmp++; if (nw - base !== 64) begin nerr++; $display("FAIL full_write_count got=%0d exp=64", nw - base); end
    ncmp++; if (log_addr[base+63] !== 6'd63 || log_data[base+63] !== 32'h103F || log_addr[base+10] !== 6'd10) begin
      nerr++; $display("FAIL full_write_last got=%0h:%0h exp=3f:103f", log_addr[base+63], log_data[base+63]); end
    wait_run(n);
    ncmp++; if (n !== 6) begin nerr++; $display("FAIL full_hold_cycles got=%0d exp=6", n); end
    core_raddr = 32'd64; core_halted = 1'b1;
    wait_term(n);
    core_raddr = 32'd0; core_halted = 1'b0;
    ncmp++; if ({done, fault, timeout} !== 3'b100) begin
      nerr++; $display("FAIL halt_beats_oob got=%b exp=100", {done, fault, timeout}); end
  endtask

  task automatic test_timeout();
    int n;
    pulse_start();
    load_one(32'h0);
    wait_run(n);
    core_raddr = 32'd5;
    n = 0;
    while (core_reset === 1'b0 && n < 100) begin n++; tick(); end
    ncmp++; if (n !== 20) begin nerr++; $display("FAIL timeout_run_cycles got=%0d exp=20", n); end
    ncmp++; if ({timeout, done, fault, core_reset, busy} !== 5'b10010) begin
      nerr++; $display("FAIL timeout_flags got=%b exp=10010", {timeout, done, fault, core_reset, busy}); end
    ncmp++; if (cycle_count !== 32'd20) begin nerr++; $display("FAIL timeout_cycle_count got=%0d exp=20", cycle_count); end
    core_raddr = 32'd0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    pulse_start();
    load_one(32'h1);
    wait_run(n);
    repeat (3) tick();
    load_valid = 1'b1; load_data = 32'hDEAD;
    reset_n = 1'b0;
    #1;
    ncmp++; if ({core_reset, busy, done, timeout, fault, load_ready, imem_wen} !== 7'b1000000) begin
      nerr++; $display("FAIL async_reset_flags got=%b exp=1000000", {core_reset, busy, done, timeout, fault, load_ready, imem_wen}); end
    ncmp++; if ({imem_waddr, imem_wdata, words_loaded, cycle_count} !== '0) begin
      nerr++; $display("FAIL async_reset_values addr=%0h data=%0h words=%0d cyc=%0d", imem_waddr, imem_wdata, words_loaded, cycle_count); end
    load_valid = 1'b0; load_data = 32'd0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef MIPS32_RUN_CTRL_RERUN_EN
  task automatic test_rerun();
    int n;
    pulse_start();
    load_one(32'h2);
    wait_run(n);
    core_halted = 1'b1;
    wait_term(n);
    core_halted = 1'b0;
    rerun = 1'b1; tick(); rerun = 1'b0;
    ncmp++; if ({busy, core_reset, done} !== 3'b110 || cycle_count !== 32'd0 || words_loaded !== 7'd1) begin
      nerr++; $display("FAIL rerun_entry got=%b cyc=%0d words=%0d exp=110/0/1", {busy, core_reset, done}, cycle_count, words_loaded); end
    wait_run(n);
    ncmp++; if (n !== 7) begin nerr++; $display("FAIL rerun_hold_cycles got=%0d exp=7", n); end
    ncmp++; if (cycle_count !== 32'd0) begin nerr++; $display("FAIL rerun_cycle_start got=%0d exp=0", cycle_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load_run();
    test_toggle_valid();
    test_full_load();
    test_timeout();
    test_reset_mid_run();
`ifdef MIPS32_RUN_CTRL_RERUN_EN
    test_rerun();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
